// File: rtl/sinc_ctrl_pkg.sv
// Shared definitions for the sinc filter capture controller: FSM state codes,
// minimum oversample ratio and filter-clear duration.
package sinc_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    localparam logic [9:0] OSR_MIN      = 10'd4;
    localparam int         CLEAR_CYCLES = 2;

    // Ratios below the filter's minimum are raised to the minimum.
    function automatic logic [9:0] clamp_osr(input logic [9:0] osr);
        return (osr < OSR_MIN) ? OSR_MIN : osr;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample buffer between the filter and the consumer. A push on a full buffer
// is accepted only when a pop happens in the same cycle.
module sample_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // The head reads as zero whenever nothing is buffered.
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/sinc_capture_ctrl.sv
// Capture sequencer for a sinc decimation filter: clears and settles the
// filter, buffers a counted (or continuous) run of samples, then drains.
module sinc_capture_ctrl
    import sinc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [9:0]            osr_in,
    input  logic [15:0]           count_in,
    output logic                  filt_rst_out,
    output logic                  filt_enable_out,
    output logic [9:0]            filt_osr_out,
    input  logic                  filt_valid_in,
    input  logic [DATA_WIDTH-1:0] filt_data_in,
    output logic                  sample_valid_out,
    input  logic                  sample_ready_in,
    output logic [DATA_WIDTH-1:0] sample_data_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  overrun_out
);

    logic [2:0]  state_q, state_d;
    logic [1:0]  clr_cnt_q, clr_cnt_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic [15:0] remain_q, remain_d;
    logic        cont_q, cont_d;
    logic [9:0]  osr_q, osr_d;
    logic        overrun_q, overrun_d;
    logic        done_q, done_d;
    logic        fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fifo_pop         = sample_valid_out && sample_ready_in;
    assign sample_valid_out = !fifo_empty;
    assign filt_rst_out     = (state_q == ST_CLEAR);
    assign filt_enable_out  = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign filt_osr_out     = osr_q;
    assign busy_out         = (state_q != ST_IDLE);
    assign done_out         = done_q;
    assign overrun_out      = overrun_q;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        settle_cnt_d = settle_cnt_q;
        remain_d     = remain_q;
        cont_d       = cont_q;
        osr_d        = osr_q;
        overrun_d    = overrun_q;
        done_d       = 1'b0;
        fifo_flush   = 1'b0;
        fifo_push    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_in && !abort_in) begin
                    osr_d      = clamp_osr(osr_in);
                    remain_d   = count_in;
                    cont_d     = (count_in == 16'd0);
                    overrun_d  = 1'b0;
                    fifo_flush = 1'b1;
                    clr_cnt_d  = 2'd0;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == 2'(CLEAR_CYCLES - 1)) begin
                    settle_cnt_d = 16'd0;
                    state_d      = (SETTLE_CNT == 0) ? ST_CAPTURE : ST_SETTLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 2'd1;
                end
            end
            ST_SETTLE: begin
                if (filt_valid_in) begin
                    if (settle_cnt_q == 16'(SETTLE_CNT - 1)) state_d = ST_CAPTURE;
                    else settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            ST_CAPTURE: begin
                // A word that cannot be stored is still counted as captured.
                if (filt_valid_in) begin
                    fifo_push = 1'b1;
                    if (fifo_full && !fifo_pop) overrun_d = 1'b1;
                    if (!cont_q) begin
                        remain_d = remain_q - 16'd1;
                        if (remain_q == 16'd1) state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_in && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            done_d     = 1'b0;
            overrun_d  = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            settle_cnt_q <= '0;
            remain_q     <= '0;
            cont_q       <= 1'b0;
            osr_q        <= OSR_MIN;
            overrun_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            remain_q     <= remain_d;
            cont_q       <= cont_d;
            osr_q        <= osr_d;
            overrun_q    <= overrun_d;
            done_q       <= done_d;
        end
    end

    sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (filt_data_in),
        .pop_i       (fifo_pop),
        .pop_data_o  (sample_data_out),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_sinc_capture_ctrl.sv
// Directed bench for sinc_capture_ctrl: counted capture, overrun, continuous
// capture with abort, ignored restart, OSR clamping and mid-capture reset.
module tb_sinc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic        abort_in;
    logic [9:0]  osr_in;
    logic [15:0] count_in;
    logic        filt_rst_out;
    logic        filt_enable_out;
    logic [9:0]  filt_osr_out;
    logic        filt_valid_in;
    logic [31:0] filt_data_in;
    logic        sample_valid_out;
    logic        sample_ready_in;
    logic [31:0] sample_data_out;
    logic        busy_out;
    logic        done_out;
    logic        overrun_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sinc_capture_ctrl #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .SETTLE_CNT (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_in         (start_in),
        .abort_in         (abort_in),
        .osr_in           (osr_in),
        .count_in         (count_in),
        .filt_rst_out     (filt_rst_out),
        .filt_enable_out  (filt_enable_out),
        .filt_osr_out     (filt_osr_out),
        .filt_valid_in    (filt_valid_in),
        .filt_data_in     (filt_data_in),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .sample_data_out  (sample_data_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .overrun_out      (overrun_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] osr, input logic [15:0] count);
        osr_in   = osr;
        count_in = count;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] data);
        filt_valid_in = 1'b1;
        filt_data_in  = data;
        tick();
        filt_valid_in = 1'b0;
    endtask

    task automatic clearAndSettle();
        tick();
        tick();
        for (int i = 0; i < 3; i++) strobe(32'hDEAD_0000 + 32'(i));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy_out), 32'd0);
        checkOutput({tag, "_osr"}, 32'(filt_osr_out), 32'd4);
        checkOutput({tag, "_valid"}, 32'(sample_valid_out), 32'd0);
        checkOutput({tag, "_data"}, sample_data_out, 32'd0);
        checkOutput({tag, "_done"}, 32'(done_out), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun_out), 32'd0);
        checkOutput({tag, "_frst"}, 32'(filt_rst_out), 32'd0);
        checkOutput({tag, "_fen"}, 32'(filt_enable_out), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        start_in        = 1'b0;
        abort_in        = 1'b0;
        osr_in          = 10'd0;
        count_in        = 16'd0;
        filt_valid_in   = 1'b0;
        filt_data_in    = 32'd0;
        sample_ready_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkResetState("reset");

        // Counted capture of 5 with a consumer that is always ready
        sample_ready_in = 1'b1;
        applyStimulus(10'd64, 16'd5);
        checkOutput("t1_clr1_frst", 32'(filt_rst_out), 32'd1);
        checkOutput("t1_clr1_fen", 32'(filt_enable_out), 32'd0);
        checkOutput("t1_busy", 32'(busy_out), 32'd1);
        checkOutput("t1_osr", 32'(filt_osr_out), 32'd64);
        tick();
        checkOutput("t1_clr2_frst", 32'(filt_rst_out), 32'd1);
        checkOutput("t1_clr2_fen", 32'(filt_enable_out), 32'd0);
        tick();
        checkOutput("t1_settle_frst", 32'(filt_rst_out), 32'd0);
        checkOutput("t1_settle_fen", 32'(filt_enable_out), 32'd1);
        for (int i = 0; i < 3; i++) strobe(32'hDEAD_0000 + 32'(i));
        checkOutput("t1_discard", 32'(sample_valid_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            strobe(32'h1000 + 32'(i));
            checkOutput("t1_valid", 32'(sample_valid_out), 32'd1);
            checkOutput("t1_data", sample_data_out, 32'h1000 + 32'(i));
            checkOutput("t1_nodone", 32'(done_out), 32'd0);
            tick();
            checkOutput("t1_popped", 32'(sample_valid_out), 32'd0);
        end
        tick();
        checkOutput("t1_done", 32'(done_out), 32'd1);
        checkOutput("t1_idle", 32'(busy_out), 32'd0);
        checkOutput("t1_fen_off", 32'(filt_enable_out), 32'd0);
        tick();
        checkOutput("t1_done_pulse", 32'(done_out), 32'd0);

        // Count 8, consumer stalled for 6 strobes: 2 words dropped
        sample_ready_in = 1'b0;
        applyStimulus(10'd64, 16'd8);
        clearAndSettle();
        for (int i = 0; i < 6; i++) begin
            strobe(32'h2000 + 32'(i));
            if (i == 3) checkOutput("t2_full_no_ovr", 32'(overrun_out), 32'd0);
        end
        checkOutput("t2_overrun", 32'(overrun_out), 32'd1);
        sample_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("t2_order", sample_data_out, 32'h2000 + 32'(k));
            tick();
        end
        checkOutput("t2_empty", 32'(sample_valid_out), 32'd0);
        checkOutput("t2_still_busy", 32'(busy_out), 32'd1);
        for (int j = 0; j < 2; j++) begin
            strobe(32'h2100 + 32'(j));
            checkOutput("t2_tail", sample_data_out, 32'h2100 + 32'(j));
            tick();
        end
        tick();
        checkOutput("t2_done", 32'(done_out), 32'd1);
        checkOutput("t2_ovr_kept", 32'(overrun_out), 32'd1);

        // Continuous capture, clamped OSR, full-buffer push+pop, abort
        sample_ready_in = 1'b0;
        applyStimulus(10'd2, 16'd0);
        checkOutput("t3_osr_clamp", 32'(filt_osr_out), 32'd4);
        checkOutput("t3_ovr_cleared", 32'(overrun_out), 32'd0);
        clearAndSettle();
        for (int i = 0; i < 4; i++) strobe(32'h3000 + 32'(i));
        sample_ready_in = 1'b1;
        strobe(32'h3004);
        sample_ready_in = 1'b0;
        checkOutput("t3_pushpop_no_ovr", 32'(overrun_out), 32'd0);
        sample_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("t3_occupancy", sample_data_out, 32'h3001 + 32'(k));
            tick();
        end
        checkOutput("t3_drained", 32'(sample_valid_out), 32'd0);
        sample_ready_in = 1'b0;
        osr_in   = 10'd100;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        checkOutput("t3_restart_osr", 32'(filt_osr_out), 32'd4);
        checkOutput("t3_restart_fen", 32'(filt_enable_out), 32'd1);
        for (int i = 5; i < 10; i++) strobe(32'h3000 + 32'(i));
        checkOutput("t3_cont_busy", 32'(busy_out), 32'd1);
        checkOutput("t3_cont_ovr", 32'(overrun_out), 32'd1);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        checkOutput("t3_abort_busy", 32'(busy_out), 32'd0);
        checkOutput("t3_abort_valid", 32'(sample_valid_out), 32'd0);
        checkOutput("t3_abort_fen", 32'(filt_enable_out), 32'd0);
        checkOutput("t3_abort_done", 32'(done_out), 32'd0);
        checkOutput("t3_abort_ovr", 32'(overrun_out), 32'd1);
        tick();
        checkOutput("t3_abort_done2", 32'(done_out), 32'd0);

        // Wide OSR, overrun, then reset in the middle of capture
        applyStimulus(10'd512, 16'd10);
        checkOutput("t4_osr512", 32'(filt_osr_out), 32'd512);
        clearAndSettle();
        for (int i = 0; i < 5; i++) strobe(32'h4000 + 32'(i));
        checkOutput("t4_ovr", 32'(overrun_out), 32'd1);
        checkOutput("t4_valid", 32'(sample_valid_out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetState("t4_rst");
        tick();
        checkOutput("t4_rst_stay", 32'(busy_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sinc_capture_ctrl.md
SINC_CAPTURE_CTRL -- requirements
Module: sinc_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, filter sample width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, sample buffer entries.
REQ-003 SHALL have parameter SETTLE_CNT, default 3, filter outputs discarded after each filter clear.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_in  input  1  one-cycle capture request.
REQ-007 SHALL have port abort_in  input  1  cancel capture.
REQ-008 SHALL have port osr_in  input  10  oversample ratio request.
REQ-009 SHALL have port count_in  input  16  samples to capture; 0 = continuous.
REQ-010 SHALL have port filt_rst_out  output  1  filter clear.
REQ-011 SHALL have port filt_enable_out  output  1  filter enable.
REQ-012 SHALL have port filt_osr_out  output  10  latched ratio to filter.
REQ-013 SHALL have port filt_valid_in  input  1  filter output strobe.
REQ-014 SHALL have port filt_data_in  input  DATA_WIDTH  filter output word.
REQ-015 SHALL have port sample_valid_out  output  1  buffered sample available.
REQ-016 SHALL have port sample_ready_in  input  1  consumer accepts sample.
REQ-017 SHALL have port sample_data_out  output  DATA_WIDTH  buffer head word.
REQ-018 SHALL have ports busy_out (1, state != IDLE), done_out (1, one-cycle pulse) and overrun_out (1, sticky), all outputs.

Function
REQ-019 SHALL implement FSM IDLE -> CLEAR -> SETTLE -> CAPTURE -> DRAIN -> IDLE.
REQ-020 IDLE: start_in=1 SHALL latch osr_in (values < 4 replaced by 4) and count_in, clear overrun_out, flush buffer, enter CLEAR.
REQ-021 CLEAR SHALL assert filt_rst_out for exactly 2 cycles with filt_enable_out=0, then enter SETTLE.
REQ-022 SETTLE and CAPTURE SHALL hold filt_enable_out=1; every other state SHALL hold it at 0.
REQ-023 SETTLE SHALL discard the first SETTLE_CNT filt_valid_in strobes, then enter CAPTURE; SETTLE_CNT=0 goes directly to CAPTURE.
REQ-024 CAPTURE SHALL push filt_data_in into the buffer on each filt_valid_in strobe and decrement the remaining count, 16-bit.
REQ-025 CAPTURE SHALL enter DRAIN on the cycle the last sample (count reaching 0) is pushed; count 0 SHALL never exit except via abort.
REQ-026 A strobe with buffer full SHALL drop the word, set overrun_out, and still decrement the count.
REQ-027 DRAIN SHALL wait for the buffer to empty, then pulse done_out one cycle and enter IDLE.
REQ-028 Buffer SHALL be FIFO order; pop when sample_valid_out && sample_ready_in; push and pop in the same cycle on a full buffer SHALL both succeed without overrun.
REQ-029 sample_valid_out SHALL be 1 exactly when buffer non-empty, with sample_data_out stable while valid && !ready.
REQ-030 abort_in=1 in any non-IDLE state SHALL enter IDLE next cycle, flush buffer, drop enable, suppress done_out; overrun_out retained.
REQ-031 abort_in SHALL take priority over start_in and over any same-cycle transition; start_in outside IDLE SHALL be ignored.
REQ-032 filt_osr_out SHALL change only on accepted start.

Reset
REQ-033 rst SHALL force IDLE, empty buffer, counters 0, filt_osr_out=4, all 1-bit outputs 0, sample_data_out 0, regardless of state, including mid-capture.

Structure
REQ-034 State encoding, OSR_MIN=4 and CLEAR_CYCLES=2 SHALL live in shared package sinc_ctrl_pkg.
REQ-035 The buffer SHALL be sub-module sample_fifo (DATA_WIDTH, FIFO_DEPTH, push/pop/full/empty/flush).

Verification
REQ-036 start, osr=64, count=5, ready=1 -> filt_rst_out 2 cycles, 3 strobes discarded, 5 samples out in order, done_out one pulse, busy_out 0.
REQ-037 count=8, ready=0 until 6 strobes, FIFO_DEPTH=4 -> 2 words dropped, overrun_out=1, 4 oldest delivered, done after drain.
REQ-038 osr_in=2 -> filt_osr_out=4; osr_in=512 -> filt_osr_out=512.
REQ-039 count=0, abort after 10 samples -> IDLE next cycle, sample_valid_out 0, no done_out, filt_enable_out 0.
REQ-040 start_in during CAPTURE with new osr -> ignored, filt_osr_out unchanged; rst mid-CAPTURE -> all outputs at REQ-033 values next cycle.
REQ-041 full buffer, strobe and pop same cycle -> no overrun, occupancy stays 4.
